// File: rtl/writeback_unit.sv
// RV32I writeback stage: merges single-cycle ALU results with one outstanding load into a registered RF write port.
// Latency: ALU result 1 cycle after handshake. Load data 1 cycle after mem_rvalid. A returning load stalls the ALU for one cycle.
module writeback_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    input  logic        ld_req_valid,
    output logic        ld_req_ready,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ld_busy,
    output logic [4:0]  ld_busy_rd,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        LD_WB    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_lo_q, ld_lo_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;

    logic        alu_fire;
    logic        ld_capture;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;

    assign ld_capture = (state_q == WAIT_MEM) && mem_rvalid;
    assign alu_ready  = !ld_capture;
    assign alu_fire   = alu_valid && alu_ready;

    assign ld_req_ready = (state_q == IDLE);
    assign ld_busy      = (state_q != IDLE);
    assign ld_busy_rd   = ld_busy ? ld_rd_q : 5'd0;

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Halfword select ignores addr bit 0; misaligned halfwords are not trapped here.
    always_comb begin
        byte_sel = 8'h00;
        case (ld_lo_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = ld_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        ld_data = mem_rdata;
        case (ld_f3_q)
            3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  ld_data = {24'h000000, byte_sel};
            3'b101:  ld_data = {16'h0000, half_sel};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ld_rd_d    = ld_rd_q;
        ld_f3_d    = ld_f3_q;
        ld_lo_d    = ld_lo_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            IDLE: begin
                if (ld_req_valid) begin
                    ld_rd_d = ld_rd;
                    ld_f3_d = ld_funct3;
                    ld_lo_d = ld_addr_lo;
                    state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    rf_we_d    = (ld_rd_q != 5'd0);
                    rf_waddr_d = ld_rd_q;
                    rf_wdata_d = ld_data;
                    state_d    = LD_WB;
                end
            end
            LD_WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // alu_ready is low whenever a load is captured, so these never collide.
        if (alu_fire) begin
            rf_we_d    = (alu_rd != 5'd0);
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ld_rd_q    <= 5'd0;
            ld_f3_q    <= 3'd0;
            ld_lo_q    <= 2'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ld_rd_q    <= ld_rd_d;
            ld_f3_q    <= ld_f3_d;
            ld_lo_q    <= ld_lo_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU path, load extraction, collisions, x0 and reset behaviour.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ld_busy;
    logic [4:0]  ld_busy_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    writeback_unit dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_result   (alu_result),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_rd        (ld_rd),
        .ld_funct3    (ld_funct3),
        .ld_addr_lo   (ld_addr_lo),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .ld_busy      (ld_busy),
        .ld_busy_rd   (ld_busy_rd),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr got %0d want 0", rf_waddr); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata got %h want 0", rf_wdata); else pass_cnt++;
        total_cnt++; if (ld_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", ld_busy); else pass_cnt++;
        total_cnt++; if (ld_busy_rd !== 5'd0) $display("FAIL reset_busy_rd got %0d want 0", ld_busy_rd); else pass_cnt++;
        total_cnt++; if (ld_req_ready !== 1'b1) $display("FAIL reset_ld_req_ready got %b want 1", ld_req_ready); else pass_cnt++;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready got %b want 1", alu_ready); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu(input logic [4:0] rd, input logic [31:0] res);
        alu_valid = 1'b1; alu_rd = rd; alu_result = res;
        tick();
        alu_valid = 1'b0;
        total_cnt++; if (rf_we !== (rd != 5'd0)) $display("FAIL alu_we rd=%0d got %b want %b", rd, rf_we, rd != 5'd0); else pass_cnt++;
        total_cnt++; if (rf_waddr !== rd) $display("FAIL alu_waddr got %0d want %0d", rf_waddr, rd); else pass_cnt++;
        total_cnt++; if (rf_wdata !== res) $display("FAIL alu_wdata got %h want %h", rf_wdata, res); else pass_cnt++;
        tick();
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL alu_idle_we got %b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (rf_wdata !== res) $display("FAIL alu_hold_wdata got %h want %h", rf_wdata, res); else pass_cnt++;
    endtask

    // Request in cycle 0, data returned `gap` cycles later.
    task automatic test_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                             input logic [31:0] data, input logic [31:0] exp, input int gap);
        ld_req_valid = 1'b1; ld_funct3 = f3; ld_addr_lo = lo; ld_rd = rd;
        #1;
        total_cnt++; if (ld_req_ready !== 1'b1) $display("FAIL ld_req_ready_idle got %b want 1", ld_req_ready); else pass_cnt++;
        tick();
        ld_req_valid = 1'b0;
        for (int i = 1; i < gap; i++) begin
            total_cnt++; if (ld_busy !== 1'b1 || ld_busy_rd !== rd || ld_req_ready !== 1'b0)
                $display("FAIL ld_wait busy=%b rd=%0d rdy=%b want 1 %0d 0", ld_busy, ld_busy_rd, ld_req_ready, rd);
            else pass_cnt++;
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = data;
        #1;
        total_cnt++; if (alu_ready !== 1'b0) $display("FAIL ld_alu_ready got %b want 0", alu_ready); else pass_cnt++;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'hA5A5A5A5;
        total_cnt++; if (rf_we !== (rd != 5'd0)) $display("FAIL ld_we rd=%0d got %b want %b", rd, rf_we, rd != 5'd0); else pass_cnt++;
        total_cnt++; if (rf_waddr !== rd) $display("FAIL ld_waddr got %0d want %0d", rf_waddr, rd); else pass_cnt++;
        total_cnt++; if (rf_wdata !== exp) $display("FAIL ld_wdata f3=%0d lo=%0d got %h want %h", f3, lo, rf_wdata, exp); else pass_cnt++;
        total_cnt++; if (ld_busy !== 1'b1 || ld_busy_rd !== rd) $display("FAIL ld_wb_busy got %b/%0d want 1/%0d", ld_busy, ld_busy_rd, rd); else pass_cnt++;
        tick();
        total_cnt++; if (ld_busy !== 1'b0 || ld_req_ready !== 1'b1 || rf_we !== 1'b0)
            $display("FAIL ld_done busy=%b rdy=%b we=%b want 0 1 0", ld_busy, ld_req_ready, rf_we);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        ld_req_valid = 1'b1; ld_funct3 = 3'b010; ld_addr_lo = 2'd0; ld_rd = 5'd9;
        tick();
        ld_req_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'hCAFEF00D;
        #1;
        total_cnt++; if (alu_ready !== 1'b0) $display("FAIL coll_alu_ready got %b want 0", alu_ready); else pass_cnt++;
        tick();
        mem_rvalid = 1'b0;
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL coll_alu_ready_wb got %b want 1", alu_ready); else pass_cnt++;
        total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h11112222)
            $display("FAIL coll_load got %b/%0d/%h want 1/9/11112222", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        tick();
        alu_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hCAFEF00D)
            $display("FAIL coll_alu got %b/%0d/%h want 1/3/cafef00d", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_simultaneous();
        ld_req_valid = 1'b1; ld_funct3 = 3'b010; ld_addr_lo = 2'd0; ld_rd = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_result = 32'h00000055;
        tick();
        ld_req_valid = 1'b0; alu_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h55)
            $display("FAIL simul_alu got %b/%0d/%h want 1/6/55", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        total_cnt++; if (ld_busy !== 1'b1 || ld_busy_rd !== 5'd4) $display("FAIL simul_busy got %b/%0d want 1/4", ld_busy, ld_busy_rd); else pass_cnt++;
        mem_rvalid = 1'b1; mem_rdata = 32'h00000077;
        tick();
        mem_rvalid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h77)
            $display("FAIL simul_load got %b/%0d/%h want 1/4/77", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'h00000001;
        tick();
        alu_rd = 5'd2; alu_result = 32'h00000002;
        total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h1)
            $display("FAIL b2b_0 got %b/%0d/%h want 1/1/1", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        tick();
        alu_rd = 5'd31; alu_result = 32'hFFFFFFFF;
        total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h2)
            $display("FAIL b2b_1 got %b/%0d/%h want 1/2/2", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        tick();
        alu_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'hFFFFFFFF)
            $display("FAIL b2b_2 got %b/%0d/%h want 1/31/ffffffff", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        ld_req_valid = 1'b1; ld_funct3 = 3'b010; ld_addr_lo = 2'd0; ld_rd = 5'd10;
        tick();
        ld_req_valid = 1'b0;
        total_cnt++; if (ld_busy !== 1'b1) $display("FAIL rmid_busy_pre got %b want 1", ld_busy); else pass_cnt++;
        rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd12; alu_result = 32'h12121212;
        tick();
        rst = 1'b0; alu_valid = 1'b0;
        total_cnt++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
            $display("FAIL rmid_prio got %b/%0d/%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        else pass_cnt++;
        mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
        tick();
        mem_rvalid = 1'b0;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL rmid_no_write got %b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (ld_busy !== 1'b0 || ld_req_ready !== 1'b1 || ld_busy_rd !== 5'd0)
            $display("FAIL rmid_idle busy=%b rdy=%b rd=%0d want 0 1 0", ld_busy, ld_req_ready, ld_busy_rd);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        rst = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_result = 32'd0;
        ld_req_valid = 1'b0; ld_rd = 5'd0; ld_funct3 = 3'd0; ld_addr_lo = 2'd0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        #2;
        test_reset();
        test_alu(5'd5, 32'hDEADBEEF);
        test_alu(5'd0, 32'h00001234);
        test_load(3'b000, 2'd3, 5'd7,  32'h80FF0011, 32'hFFFFFF80, 3);
        test_load(3'b101, 2'd2, 5'd8,  32'h80011234, 32'h00008001, 1);
        test_load(3'b001, 2'd0, 5'd11, 32'h0000F00D, 32'hFFFFF00D, 2);
        test_load(3'b001, 2'd3, 5'd12, 32'h9ABC0000, 32'hFFFF9ABC, 1);
        test_load(3'b100, 2'd1, 5'd13, 32'h12345678, 32'h00000056, 1);
        test_load(3'b011, 2'd2, 5'd14, 32'h0BADF00D, 32'h0BADF00D, 1);
        test_load(3'b010, 2'd0, 5'd0,  32'h13579BDF, 32'h13579BDF, 2);
        test_collision();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
